hazard_unit_sb: RTL
===================

// Module: hazard_unit_sb
// PURPOSE
//  Next-generation hazard unit for the 5-stage RV64I core: M/W operand forwarding,
//  load-use and JALR stalls, branch flushes, plus a register scoreboard. The scoreboard
//  tracks results owed by an out-of-band multi-cycle unit (divider / long ops).
//  Sits beside the pipeline registers; drives Stall_F/D, Flush_D/E/M and forward selects.
// PARAMETERS
//  REG_AW   5   register index width; NUM_REGS = 2**REG_AW
//  MC_DEPTH 2   max outstanding multi-cycle ops (1..NUM_REGS-1)
//  PERF_W   32  width of performance counters (HAZ_PERF_EN only)
// PORTS
//  clk          in  1       core clock
//  rst_n        in  1       asynchronous reset, active low
//  Rs1_D,Rs2_D  in  REG_AW  decode source regs
//  Rs1_Used_D,Rs2_Used_D in 1  source actually read by decode instr
//  Rd_D         in  REG_AW  decode dest reg;  RegWrite_D in 1
//  is_jalr_D    in  1       decode instr is JALR
//  is_mc_D      in  1       decode instr issues to multi-cycle unit
//  Rs1_E,Rs2_E,Rd_E in REG_AW;  RegWrite_E in 1;  ResultSrc_E in 2 (2'b01 = load)
//  PCSrc_E      in  1       taken branch/jump redirect from execute
//  mc_start_E   in  1       multi-cycle op leaving E this cycle, dest Rd_E
//  mc_done      in  1       multi-cycle result written to regfile this cycle
//  mc_done_rd   in  REG_AW  dest of completing op
//  Rd_M         in  REG_AW;  RegWrite_M in 1;  Rd_W in REG_AW;  RegWrite_W in 1
//  ForwardA_E,ForwardB_E out 2  00 regfile, 01 from W, 10 from M
//  Stall_F,Stall_D out 1;  Flush_D,Flush_E,Flush_M out 1
//  mc_busy      out 1       outstanding count != 0
//  stall_cyc,flush_cyc out PERF_W  counters (HAZ_PERF_EN)
// BEHAVIOUR
//  - Forwarding combinational: M beats W; never forward for Rs==0 or RegWrite low.
//  - lwStall = ResultSrc_E==01 & Rd_E!=0 & ((Rs1_Used_D&Rs1_D==Rd_E)|(Rs2_Used_D&Rs2_D==Rd_E)).
//  - jalrStall = is_jalr_D & RegWrite_E & Rd_E!=0 & Rs1_D==Rd_E.
//  - sbStall (registered busy[] vector, bit 0 hardwired 0):
//      RAW: used Rs_D with busy[Rs_D]; WAW: RegWrite_D & busy[Rd_D];
//      structural: is_mc_D & (count==MC_DEPTH).
//  - raw = lwStall|jalrStall|sbStall; stall = raw & ~PCSrc_E (redirect wins; D is wrong-path).
//  - Stall_F=Stall_D=stall; Flush_D=PCSrc_E; Flush_E=PCSrc_E|stall; Flush_M=0.
//  - Scoreboard, clocked: mc_start_E & Rd_E!=0 sets busy[Rd_E];
//    mc_done clears busy[mc_done_rd]; same reg same cycle -> set wins.
//  - count: +1 on start, -1 on done, unchanged if both. Start at MC_DEPTH or done at 0 is
//    illegal: assertion fires, count saturates.
//  - Release latency: D waiting on busy reg stalls through the mc_done cycle; issues the
//    following cycle (regfile is write-first, no MC forwarding path).
//  - Reset (async, rst_n=0): busy=0, count=0, counters=0; reset mid-op discards
//    outstanding ops. Outputs follow inputs combinationally from then on.
// CONFIGURATION
//  HAZ_PERF_EN defined: stall_cyc +1 per cycle with stall=1, flush_cyc +1 per cycle with
//    Flush_E=1; both saturate at all-ones.
//  HAZ_PERF_EN undefined: no counter flops; stall_cyc/flush_cyc tied to 0.
// STRUCTURE
//  hazard_pkg: fwd_sel_e enum (FWD_RF=2'b00, FWD_W=2'b01, FWD_M=2'b10),
//    RESULT_LOAD=2'b01, REG_AW default.
//  Sub-module hazard_scoreboard: busy[] vector, outstanding counter, RAW/WAW/full query
//    ports. Top keeps forwarding, stall/flush combination, perf counters.
// TESTING
//  1 Rd_M=5,RegWrite_M,Rs1_E=5; Rd_W=5,RegWrite_W -> ForwardA_E=10; Rs1_E=0 -> 00.
//  2 load Rd_E=7, Rs2_D=7 with Rs2_Used_D=1 -> one-cycle Stall_F/D+Flush_E;
//    Rs2_Used_D=0 -> no stall.
//  3 mc_start_E Rd_E=9; 6 cycles later Rs1_D=9 -> stall until mc_done rd=9,
//    deasserts next cycle.
//  4 MC_DEPTH=2: two starts, is_mc_D -> structural stall; one done -> clears next cycle.
//  5 stall condition with PCSrc_E=1 -> Stall_D=0, Flush_D=Flush_E=1.
//  6 busy[3] set, rst_n low mid-cycle -> busy/count 0 immediately;
//    HAZ_PERF_EN counters 0 and count 3 after three stall cycles.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared types and constants for the RV64I hazard unit and its register scoreboard.
package hazard_pkg;

  localparam int REG_AW_DEF = 5;

  // ResultSrc encoding that marks a load in the execute stage.
  localparam logic [1:0] RESULT_LOAD = 2'b01;

  typedef enum logic [1:0] {
    FWD_RF = 2'b00,
    FWD_W  = 2'b01,
    FWD_M  = 2'b10
  } fwd_sel_e;

endpackage

// File: rtl/hazard_scoreboard.sv
// Busy-register scoreboard for results owed by the out-of-band multi-cycle unit,
// with RAW / WAW / unit-full queries for the instruction sitting in decode.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int REG_AW   = REG_AW_DEF,
  parameter int MC_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [REG_AW-1:0] start_rd,
  input  logic              done,
  input  logic [REG_AW-1:0] done_rd,
  input  logic [REG_AW-1:0] rs1,
  input  logic              rs1_used,
  input  logic [REG_AW-1:0] rs2,
  input  logic              rs2_used,
  input  logic [REG_AW-1:0] rd,
  input  logic              reg_write,
  input  logic              is_mc,
  output logic              raw_hit,
  output logic              waw_hit,
  output logic              full,
  output logic              busy_any
);

  localparam int NUM_REGS = 2 ** REG_AW;
  localparam int CNT_W    = $clog2(MC_DEPTH + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MC_DEPTH);

  // x0 never owes a result, so only entries 1..NUM_REGS-1 are stored.
  logic [NUM_REGS-1:1] busy_q;
  logic [NUM_REGS-1:1] busy_nxt;
  logic [NUM_REGS-1:0] busy_vec;
  logic [CNT_W-1:0]    count_q;

  always_comb begin
    // NOTE: busy_nxt gets a full default first so no path leaves it unassigned (no latch).
    busy_nxt = busy_q;
    if (done && done_rd != '0) busy_nxt[done_rd] = 1'b0;
    // Applied after the clear so a same-register start wins over a completion.
    if (start && start_rd != '0) busy_nxt[start_rd] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n) begin
      busy_q  <= '0;
      count_q <= '0;
    end else begin
      busy_q <= busy_nxt;
      if (start && !done) begin
        if (count_q != CNT_MAX) count_q <= count_q + 1'b1;
      end else if (done && !start) begin
        if (count_q != '0) count_q <= count_q - 1'b1;
      end
    end
  end

  assign busy_vec = {busy_q, 1'b0};
  assign raw_hit  = (rs1_used && busy_vec[rs1]) || (rs2_used && busy_vec[rs2]);
  assign waw_hit  = reg_write && busy_vec[rd];
  assign full     = is_mc && (count_q == CNT_MAX);
  assign busy_any = (count_q != '0);

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(start && !done && count_q == CNT_MAX));
  a_no_underflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(done && !start && count_q == '0));

endmodule

// File: rtl/hazard_unit_sb.sv
// 5-stage RV64I hazard unit: M/W forwarding, load-use / JALR / scoreboard stalls, redirect flushes.
// Define HAZ_PERF_EN to build the saturating stall_cyc / flush_cyc performance counters.
module hazard_unit_sb
  import hazard_pkg::*;
#(
  parameter int REG_AW   = REG_AW_DEF,
  parameter int MC_DEPTH = 2,
  parameter int PERF_W   = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [REG_AW-1:0] Rs1_D,
  input  logic [REG_AW-1:0] Rs2_D,
  input  logic              Rs1_Used_D,
  input  logic              Rs2_Used_D,
  input  logic [REG_AW-1:0] Rd_D,
  input  logic              RegWrite_D,
  input  logic              is_jalr_D,
  input  logic              is_mc_D,
  input  logic [REG_AW-1:0] Rs1_E,
  input  logic [REG_AW-1:0] Rs2_E,
  input  logic [REG_AW-1:0] Rd_E,
  input  logic              RegWrite_E,
  input  logic [1:0]        ResultSrc_E,
  input  logic              PCSrc_E,
  input  logic              mc_start_E,
  input  logic              mc_done,
  input  logic [REG_AW-1:0] mc_done_rd,
  input  logic [REG_AW-1:0] Rd_M,
  input  logic              RegWrite_M,
  input  logic [REG_AW-1:0] Rd_W,
  input  logic              RegWrite_W,
  output logic [1:0]        ForwardA_E,
  output logic [1:0]        ForwardB_E,
  output logic              Stall_F,
  output logic              Stall_D,
  output logic              Flush_D,
  output logic              Flush_E,
  output logic              Flush_M,
  output logic              mc_busy,
  output logic [PERF_W-1:0] stall_cyc,
  output logic [PERF_W-1:0] flush_cyc
);

  logic lw_stall, jalr_stall, sb_stall, stall;
  logic sb_raw, sb_waw, sb_full;

  // The younger M result beats W; x0 is never forwarded.
  function automatic fwd_sel_e fwd_for(input logic [REG_AW-1:0] rs,
                                       input logic [REG_AW-1:0] rd_m, input logic wr_m,
                                       input logic [REG_AW-1:0] rd_w, input logic wr_w);
    if (rs == '0)                 return FWD_RF;
    if (wr_m && rd_m == rs)       return FWD_M;
    if (wr_w && rd_w == rs)       return FWD_W;
    return FWD_RF;
  endfunction

  assign ForwardA_E = fwd_for(Rs1_E, Rd_M, RegWrite_M, Rd_W, RegWrite_W);
  assign ForwardB_E = fwd_for(Rs2_E, Rd_M, RegWrite_M, Rd_W, RegWrite_W);

  hazard_scoreboard #(
    .REG_AW   (REG_AW),
    .MC_DEPTH (MC_DEPTH)
  ) u_scoreboard (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (mc_start_E),
    .start_rd  (Rd_E),
    .done      (mc_done),
    .done_rd   (mc_done_rd),
    .rs1       (Rs1_D),
    .rs1_used  (Rs1_Used_D),
    .rs2       (Rs2_D),
    .rs2_used  (Rs2_Used_D),
    .rd        (Rd_D),
    .reg_write (RegWrite_D),
    .is_mc     (is_mc_D),
    .raw_hit   (sb_raw),
    .waw_hit   (sb_waw),
    .full      (sb_full),
    .busy_any  (mc_busy)
  );

  assign lw_stall   = (ResultSrc_E == RESULT_LOAD) && (Rd_E != '0) &&
                      ((Rs1_Used_D && Rs1_D == Rd_E) || (Rs2_Used_D && Rs2_D == Rd_E));
  assign jalr_stall = is_jalr_D && RegWrite_E && (Rd_E != '0) && (Rs1_D == Rd_E);
  assign sb_stall   = sb_raw || sb_waw || sb_full;

  // A redirect makes the decode instruction wrong-path, so it is flushed rather than held.
  assign stall   = (lw_stall || jalr_stall || sb_stall) && !PCSrc_E;
  assign Stall_F = stall;
  assign Stall_D = stall;
  assign Flush_D = PCSrc_E;
  assign Flush_E = PCSrc_E || stall;
  assign Flush_M = 1'b0;

`ifdef HAZ_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cyc <= '0;
      flush_cyc <= '0;
    end else begin
      if (stall && stall_cyc != '1)   stall_cyc <= stall_cyc + 1'b1;
      if (Flush_E && flush_cyc != '1) flush_cyc <= flush_cyc + 1'b1;
    end
  end
`else
  assign stall_cyc = '0;
  assign flush_cyc = '0;
`endif

endmodule
